// File: rtl/frame_output_writer_if.sv
// frame_output_writer_if: start/pixel-beat/memory-write bundle for frame_output_writer.
// frame_checksum exists only when FRAME_OUTPUT_CHECKSUM_EN is defined.
interface frame_output_writer_if #(
    parameter int PIXEL_WIDTH = 10
);
    logic                      start;
    logic [15:0]               frame_width;
    logic [15:0]               frame_height;
    logic                      in_valid;
    logic                      in_ready;
    logic [16*PIXEL_WIDTH-1:0] in_data;
    logic                      in_last;
    logic                      mem_wr_en;
    logic                      mem_ready;
    logic [15:0]               mem_addr;
    logic [16*PIXEL_WIDTH-1:0] mem_wr_data;
    logic [15:0]               mem_lane_mask;
    logic                      busy;
    logic                      frame_done;
    logic                      underrun_err;
`ifdef FRAME_OUTPUT_CHECKSUM_EN
    logic [31:0]               frame_checksum;
    modport master (
        output start, frame_width, frame_height, in_valid, in_data, in_last, mem_ready,
        input  in_ready, mem_wr_en, mem_addr, mem_wr_data, mem_lane_mask, busy, frame_done,
        input  underrun_err, frame_checksum
    );
    modport slave (
        input  start, frame_width, frame_height, in_valid, in_data, in_last, mem_ready,
        output in_ready, mem_wr_en, mem_addr, mem_wr_data, mem_lane_mask, busy, frame_done,
        output underrun_err, frame_checksum
    );
`else
    modport master (
        output start, frame_width, frame_height, in_valid, in_data, in_last, mem_ready,
        input  in_ready, mem_wr_en, mem_addr, mem_wr_data, mem_lane_mask, busy, frame_done,
        input  underrun_err
    );
    modport slave (
        input  start, frame_width, frame_height, in_valid, in_data, in_last, mem_ready,
        output in_ready, mem_wr_en, mem_addr, mem_wr_data, mem_lane_mask, busy, frame_done,
        output underrun_err
    );
`endif
endinterface

// File: rtl/frame_output_writer.sv
// frame_output_writer: buffers 16-pixel beats of a frame and writes them to memory with lane masks.
// Optional FRAME_OUTPUT_CHECKSUM_EN adds a 32-bit sum of all written pixels.
module frame_output_writer #(
    parameter int PIXEL_WIDTH = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input logic                  clk,
    input logic                  rst,
    frame_output_writer_if.slave bus
);
    localparam int DW = 16 * PIXEL_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q;
    logic [DW-1:0]  data_q [FIFO_DEPTH];
    logic [15:0]    addr_q [FIFO_DEPTH];
    logic [15:0]    mask_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    cnt_q;
    logic [15:0]    total_q, offset_q, total_d, mask_d;
    logic           err_q, empty, full, push, pop, final_beat;

    assign empty      = cnt_q == '0;
    assign full       = cnt_q == FIFO_DEPTH[AW:0];
    assign push       = bus.in_valid && bus.in_ready;
    assign pop        = bus.mem_wr_en && bus.mem_ready;
    assign final_beat = {1'b0, offset_q} + 17'd16 >= {1'b0, total_q};

    always_comb begin
        total_d = bus.frame_width * bus.frame_height;
        mask_d  = '0;
        for (int l = 0; l < 16; l++) mask_d[l] = {1'b0, offset_q} + 17'(l) < {1'b0, total_q};
    end

`ifdef FRAME_OUTPUT_CHECKSUM_EN
    logic [31:0] checksum_q, sum_d;
    always_comb begin
        sum_d = '0;
        for (int l = 0; l < 16; l++)
            sum_d = mask_q[rd_q][l] ? sum_d + 32'(data_q[rd_q][l*PIXEL_WIDTH +: PIXEL_WIDTH]) : sum_d;
    end
    always_ff @(posedge clk) begin
        if (rst) checksum_q <= '0;
        else if (state_q == IDLE && bus.start) checksum_q <= '0;
        else if (pop) checksum_q <= checksum_q + sum_d;
    end
    assign bus.frame_checksum = checksum_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            total_q  <= '0;
            offset_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                data_q[wr_q] <= bus.in_data;
                addr_q[wr_q] <= offset_q;
                mask_q[wr_q] <= mask_d;
                wr_q         <= wr_q + 1'b1;
                offset_q     <= offset_q + 16'd16;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            case (state_q)
                IDLE: if (bus.start) begin
                    total_q  <= total_d;
                    offset_q <= '0;
                    err_q    <= 1'b0;
                    state_q  <= total_d == '0 ? DONE : RUN;
                end
                // an early in_last ends the frame but flags the missing pixels
                RUN: if (push && (final_beat || bus.in_last)) begin
                    state_q <= DRAIN;
                    err_q   <= err_q | (bus.in_last && !final_beat);
                end
                DRAIN: if (empty) state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = state_q == RUN && !full;
    assign bus.mem_wr_en     = !empty;
    assign bus.mem_addr      = empty ? '0 : addr_q[rd_q];
    assign bus.mem_wr_data   = empty ? '0 : data_q[rd_q];
    assign bus.mem_lane_mask = empty ? '0 : mask_q[rd_q];
    assign bus.busy          = state_q != IDLE;
    assign bus.frame_done    = state_q == DONE;
    assign bus.underrun_err  = err_q;
endmodule

// File: doc/frame_output_writer.md
FRAME_OUTPUT_WRITER -- requirements
Module: frame_output_writer

Interface
REQ-001 Parameter PIXEL_WIDTH, default 10, bits per pixel.
REQ-002 Parameter FIFO_DEPTH, default 4, beat buffer entries (power of two, >=2).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse, begin frame.
REQ-006 frame_width, frame_height  input  16 each  frame size in pixels, sampled on accepted start.
REQ-007 in_valid / in_ready  input / output  1 each  upstream beat handshake.
REQ-008 in_data  input  16*PIXEL_WIDTH  16 pixels, lane 0 in LSBs.
REQ-009 in_last  input  1  upstream marks final beat of frame.
REQ-010 mem_wr_en / mem_ready  output / input  1 each  memory write handshake.
REQ-011 mem_addr  output  16  pixel offset of lane 0; mem_wr_data output 16*PIXEL_WIDTH; mem_lane_mask output 16.
REQ-012 busy  output  1; frame_done  output  1 (one-cycle pulse); underrun_err  output  1 (sticky until next start).

Function
REQ-013 States IDLE, RUN, DRAIN, DONE; IDLE->RUN on start, RUN->DRAIN when final beat accepted, DRAIN->DONE when FIFO empty and last write completed, DONE->IDLE after one cycle.
REQ-014 On start, total_pixels = frame_width*frame_height truncated to 16 bits; beat counter and write offset cleared.
REQ-015 total_pixels==0: RUN skipped, IDLE->DONE, frame_done pulses, no memory write issued.
REQ-016 start outside IDLE ignored.
REQ-017 in_ready = 1 only in RUN with FIFO not full; a beat is accepted when in_valid && in_ready.
REQ-018 Final beat = beat whose accepted offset+16 >= total_pixels; after it in_ready stays 0 until next frame.
REQ-019 in_last on a non-final beat: beat accepted and written, underrun_err set, state -> DRAIN.
REQ-020 in_last absent on final beat: no error, final-beat rule governs.
REQ-021 mem_wr_en = FIFO not empty; entry popped when mem_wr_en && mem_ready; mem_addr, data, mask stable while mem_ready low.
REQ-022 mem_addr of beat k = 16*k, wrapping modulo 2^16.
REQ-023 mem_lane_mask = 16'hFFFF except final beat: lanes with offset+lane < total_pixels set, others 0.
REQ-024 Latency: beat accepted at cycle N with FIFO empty appears on memory bus at cycle N+1.
REQ-025 Simultaneous push and pop on full FIFO: pop completes, push stalled (in_ready already 0 due to full); on partially full FIFO both occur, occupancy unchanged.
REQ-026 busy = 1 in RUN, DRAIN, DONE.
REQ-027 frame_done asserted exactly one cycle in DONE.

Reset
REQ-028 On rst: state IDLE, FIFO empty, in_ready 0, mem_wr_en 0, mem_addr 0, mem_wr_data 0, mem_lane_mask 0, busy 0, frame_done 0, underrun_err 0, all counters 0.
REQ-029 rst mid-frame discards buffered beats; no further writes until next start.

Configuration
REQ-030 Macro FRAME_OUTPUT_CHECKSUM_EN: when defined, output frame_checksum (32 bits) = modulo-2^32 sum of all masked-in pixels popped to memory, cleared on accepted start and reset, valid when frame_done pulses; when undefined, port and logic absent, all other behaviour identical.

Verification
REQ-031 64x64, 256 beats, mem_ready=1 -> 256 writes, addrs 0..4080 step 16, all masks FFFF, frame_done once.
REQ-032 10x3 (30 pixels) -> 2 writes, addr 0 mask FFFF, addr 16 mask 3FFF.
REQ-033 mem_ready low 20 cycles during 64x64 frame -> in_ready low after 4 buffered beats, no beat lost or duplicated, data order preserved.
REQ-034 in_last on beat 5 of 64x64 frame -> 6 writes, underrun_err=1, frame_done pulses.
REQ-035 0x64 frame -> frame_done one cycle after start, zero writes; start while busy -> ignored.
REQ-036 rst at beat 100 then new 16x16 start -> exactly 16 writes from addr 0; with FRAME_OUTPUT_CHECKSUM_EN all pixels=1 -> frame_checksum=256.
